// File: rtl/apb_pkg.sv
// Shared state encoding, AHB transfer-type constants and address helpers
// for the single-clock AHB-to-APB bridge.
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      WDATA  = 2'b01,
      SETUP  = 2'b10,
      ACCESS = 2'b11
   } state_e;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   // NONSEQ and SEQ share htrans[1]; IDLE and BUSY never start a transfer.
   function automatic logic ahb_start(input logic hsel, input logic [1:0] htrans);
      return hsel & htrans[1];
   endfunction

   function automatic logic [31:0] apb_word_addr(input logic [31:0] haddr,
                                                 input int unsigned shift);
      return haddr >> shift;
   endfunction

endpackage

// File: rtl/ahb2apb_bridge_if.sv
// AHB slave-side and APB master-side signals of the bridge in one bundle.
// The bridge uses the slave modport; the surrounding system uses master.
interface ahb2apb_bridge_if;

   logic        hsel;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [31:0] haddr;
   logic [31:0] hwdata;
   logic        hreadyout;
   logic [31:0] hrdata;

   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        pready;

   modport slave (
      input  hsel, htrans, hwrite, haddr, hwdata, prdata, pready,
      output hreadyout, hrdata, psel, penable, pwrite, paddr, pwdata
   );

   modport master (
      output hsel, htrans, hwrite, haddr, hwdata, prdata, pready,
      input  hreadyout, hrdata, psel, penable, pwrite, paddr, pwdata
   );

endinterface

// File: rtl/ahb2apb_bridge.sv
// Single-clock AHB-to-APB bridge: one outstanding transfer, AHB wait states
// held for the whole APB SETUP/ACCESS sequence.
module ahb2apb_bridge
   import apb_pkg::*;
#(
   parameter int unsigned PADDR_SHIFT = 2
) (
   input  logic               pclk,
   input  logic               presetn,
   ahb2apb_bridge_if.slave    bus
);

   state_e      state_q, state_d;
   logic [31:0] paddr_q, paddr_d;
   logic [31:0] pwdata_q, pwdata_d;
   logic [31:0] hrdata_q, hrdata_d;
   logic        pwrite_q, pwrite_d;

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q  <= IDLE;
         paddr_q  <= '0;
         pwdata_q <= '0;
         hrdata_q <= '0;
         pwrite_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         paddr_q  <= paddr_d;
         pwdata_q <= pwdata_d;
         hrdata_q <= hrdata_d;
         pwrite_q <= pwrite_d;
      end
   end

   // AHB address-phase inputs are only looked at in IDLE; the write data
   // phase is the single WDATA cycle that follows a write acceptance.
   always_comb begin
      state_d  = state_q;
      paddr_d  = paddr_q;
      pwdata_d = pwdata_q;
      hrdata_d = hrdata_q;
      pwrite_d = pwrite_q;

      unique case (state_q)
         IDLE: begin
            if (ahb_start(bus.hsel, bus.htrans)) begin
               paddr_d  = apb_word_addr(bus.haddr, PADDR_SHIFT);
               pwrite_d = bus.hwrite;
               state_d  = bus.hwrite ? WDATA : SETUP;
            end
         end
         WDATA: begin
            pwdata_d = bus.hwdata;
            state_d  = SETUP;
         end
         SETUP: begin
            state_d = ACCESS;
         end
         ACCESS: begin
            if (bus.pready) begin
               state_d = IDLE;
               if (!pwrite_q) begin
                  hrdata_d = bus.prdata;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.psel      = (state_q == SETUP) || (state_q == ACCESS);
   assign bus.penable   = (state_q == ACCESS);
   assign bus.hreadyout = (state_q == IDLE);
   assign bus.paddr     = paddr_q;
   assign bus.pwrite    = pwrite_q;
   assign bus.pwdata    = pwdata_q;
   assign bus.hrdata    = hrdata_q;

   a_penable_needs_psel: assert property (
      @(posedge pclk) disable iff (!presetn) bus.penable |-> bus.psel);

   a_apb_stable_in_wait: assert property (
      @(posedge pclk) disable iff (!presetn)
      (state_q == ACCESS && !bus.pready) |=>
         ($stable(paddr_q) && $stable(pwrite_q) && $stable(pwdata_q)));

endmodule
